decoder_2to4_reg: RTL and testbench
===================================

Name: decoder_2to4_reg

Overview:
- Registered 2-to-4 one-hot line decoder: the 2-bit code {x1,x2} selects exactly one of four outputs a/b/c/d.
- Used as a small select/enable generator. Outputs are registered on clk for glitch-free downstream use.
- Includes an enable gate and a parameterised output polarity.

Parameters:
- ACTIVE_LOW, default 0: 0 = selected output driven 1, others 0; 1 = selected output driven 0, others 1 (all outputs inverted at the register input).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- en  input  1  decode enable; when 0, no output is selected.
- x1  input  1  code MSB.
- x2  input  1  code LSB.
- a  output  1  asserted when {x1,x2}=2'b00.
- b  output  1  asserted when {x1,x2}=2'b01.
- c  output  1  asserted when {x1,x2}=2'b10.
- d  output  1  asserted when {x1,x2}=2'b11.

Behaviour:
- "Asserted" means 1 if ACTIVE_LOW=0, 0 if ACTIVE_LOW=1. "Deasserted" is the opposite level.
- Decode function: sel = {x1,x2}; one-hot vector {d,c,b,a} = 4'b0001 << sel.
  - 00→a, 01→b, 10→c, 11→d.
  - Exactly one output is asserted whenever en=1 and rst=0.
- Enable gating: en=0 → all four outputs deasserted on the next edge (vector 4'b0000 before polarity).
- Registers: a, b, c, d are flip-flop outputs; there is no combinational path from inputs to outputs.
- Latency: 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- Reset:
  - rst=1 at a rising edge → all outputs deasserted (a=b=c=d=0 for ACTIVE_LOW=0; all 1 for ACTIVE_LOW=1).
  - Reset takes priority over en and x1/x2.
  - Reset has no asynchronous effect: between edges, outputs keep their prior value even while rst is high.
  - Reset mid-operation: the decoded value is discarded. The first valid decode appears one edge after rst falls, using the inputs sampled at that edge.
- Before the first clock edge after power-up, output values are undefined. The bench applies reset first.
- Input changes between edges have no effect. Only the value present at the rising edge matters.
- X on x1/x2 with en=1 may propagate X to the outputs. No X-recovery logic is required.
- Invariant for en=1, rst=0: popcount(asserted outputs)=1. Otherwise popcount=0.

Test Plan:
- Reset: rst=1, en=1, x1=1, x2=1 for 2 cycles → a=b=c=d=0 after each edge. Release rst → d=1, others 0 after the next edge.
- Exhaustive decode, en=1, ACTIVE_LOW=0:
  - Apply {x1,x2}=00,01,10,11 on successive edges.
  - Required one edge later: {a,b,c,d} = 1000, 0100, 0010, 0001.
- Enable gating: x1=0, x2=1, toggle en 1→0→1 on successive edges → {a,b,c,d} = 0100, 0000, 0100.
- Mid-operation reset: during a steady decode of 10 (c=1), pulse rst=1 for one edge → c=0 on that edge, then c=1 on the following edge with rst=0.
- Between-edge stability: change x1/x2 several times between two edges → outputs change only at the edge, reflecting the value sampled there.
- Polarity: ACTIVE_LOW=1, {x1,x2}=01, en=1 → {a,b,c,d}=1011. With rst=1 → 1111.

Source files
------------

// File: rtl/decoder_2to4_reg.sv
// Registered 2-to-4 one-hot decoder with enable gate and selectable output polarity.
// Outputs come straight from flops, so downstream enables never see decode glitches.
module decoder_2to4_reg #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic x1,
    input  logic x2,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    localparam logic [3:0] IDLE_LEVEL = ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [1:0] sel;
    logic [3:0] onehot;
    logic [3:0] onehot_pol;

    assign sel = {x1, x2};

    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot = 4'b0001 << sel;
        end
    end

    // Polarity is applied before the flops so the outputs stay purely registered.
    assign onehot_pol = ACTIVE_LOW ? ~onehot : onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            {d, c, b, a} <= IDLE_LEVEL;
        end else begin
            {d, c, b, a} <= onehot_pol;
        end
    end

endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Directed bench for decoder_2to4_reg; checks active-high and active-low builds in lockstep.
module tb_decoder_2to4_reg;

    logic clk;
    logic rst;
    logic en;
    logic x1;
    logic x2;
    logic a_h, b_h, c_h, d_h;
    logic a_l, b_l, c_l, d_l;

    int checks;
    int errors;

    decoder_2to4_reg #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2),
        .a(a_h), .b(b_h), .c(c_h), .d(d_h)
    );

    decoder_2to4_reg #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2),
        .a(a_l), .b(b_l), .c(c_l), .d(d_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp is {a,b,c,d} for the active-high build; the active-low build must be its complement.
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs_h;
        logic [3:0] obs_l;
        logic [3:0] exp_l;
        obs_h = {a_h, b_h, c_h, d_h};
        obs_l = {a_l, b_l, c_l, d_l};
        exp_l = ~exp;
        checks++;
        assert (obs_h === exp) else begin
            errors++;
            $error("FAIL %s (high): observed abcd=%b expected abcd=%b", tag, obs_h, exp);
        end
        checks++;
        assert (obs_l === exp_l) else begin
            errors++;
            $error("FAIL %s (low): observed abcd=%b expected abcd=%b", tag, obs_l, exp_l);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with a live decode request on the inputs.
        rst = 1'b1; en = 1'b1; x1 = 1'b1; x2 = 1'b1;
        step(); check("reset_edge1", 4'b0000);
        step(); check("reset_edge2", 4'b0000);
        rst = 1'b0;
        step(); check("reset_release_d", 4'b0001);

        // Exhaustive decode.
        {x1, x2} = 2'b00; step(); check("decode_00", 4'b1000);
        {x1, x2} = 2'b01; step(); check("decode_01", 4'b0100);
        {x1, x2} = 2'b10; step(); check("decode_10", 4'b0010);
        {x1, x2} = 2'b11; step(); check("decode_11", 4'b0001);

        // Enable gating.
        {x1, x2} = 2'b01; en = 1'b1; step(); check("en_on_a", 4'b0100);
        en = 1'b0;                   step(); check("en_off", 4'b0000);
        {x1, x2} = 2'b11;            step(); check("en_off_code11", 4'b0000);
        {x1, x2} = 2'b01; en = 1'b1; step(); check("en_on_b", 4'b0100);

        // Mid-operation reset, including no asynchronous effect between edges.
        {x1, x2} = 2'b10; step(); check("steady_c1", 4'b0010);
        step(); check("steady_c2", 4'b0010);
        rst = 1'b1; #1; check("rst_no_async", 4'b0010);
        step(); check("rst_mid", 4'b0000);
        rst = 1'b0;
        step(); check("rst_mid_release", 4'b0010);

        // Between-edge input changes must not reach the outputs.
        {x1, x2} = 2'b00; #1; check("stable_1", 4'b0010);
        {x1, x2} = 2'b11; #1; check("stable_2", 4'b0010);
        en = 1'b0;        #1; check("stable_3", 4'b0010);
        en = 1'b1; {x1, x2} = 2'b01; #1; check("stable_4", 4'b0010);
        step(); check("stable_sampled", 4'b0100);

        // Reset while holding a decode, then recover with a different code.
        rst = 1'b1; step(); check("rst_hold", 4'b0000);
        {x1, x2} = 2'b00; rst = 1'b0; step(); check("rst_recover_a", 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
